// File: rtl/sine_sample_stage.sv
// ---------------------------------------------------------------------------
// sine_sample_stage
//
// Downstream stage of the note phase accumulator. Once per audio sample
// period the running phase is captured, folded onto a quarter-wave sine ROM,
// sign-restored and handed to the mixer/PWM stage over a valid/ready
// handshake.
//
// Pipeline (one tick every CLK_DIV cycles):
//   S1  tick edge   : capture quadrant, mirrored ROM address, sign, mute flag
//   S2  +1 edge     : registered ROM read (magnitude only)
//   S3  +2 edge     : sign applied, mute forced to 0, handshake into output
//
// Ports
//   clk_in            in   1             system clock
//   rst_n_in          in   1             asynchronous active-low reset
//   phase_value_in    in   PHASE_WIDTH   running phase from the accumulator
//   gate_in           in   1             note active; 0 = mute
//   sample_ready_in   in   1             downstream accepts sample_out
//   sample_out        out  SAMPLE_WIDTH  signed two's-complement sample
//   sample_valid_out  out  1             sample_out holds an unconsumed sample
//   overrun_out       out  1             sticky: a sample was dropped
//
// Build option
//   SINE_ZERO_CROSS_MUTE_EN  when defined, muting waits for the next zero
//                            crossing (quadrant sign change) so the note
//                            releases without a click. When undefined, a
//                            low gate mutes the very next sample.
// ---------------------------------------------------------------------------
module sine_sample_stage #(
    parameter int PHASE_WIDTH    = 32,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int CLK_DIV        = 6104
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic [PHASE_WIDTH-1:0]         phase_value_in,
    input  logic                           gate_in,
    input  logic                           sample_ready_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid_out,
    output logic                           overrun_out
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int ROM_DEPTH = 2 ** LUT_ADDR_WIDTH;
    // ROM entries are always positive, so the sign bit is not stored.
    localparam int MAG_W     = SAMPLE_WIDTH - 1;
    localparam int AMPLITUDE = (2 ** (SAMPLE_WIDTH - 1)) - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // -----------------------------------------------------------------------
    // Quarter-wave ROM image, evaluated at elaboration.
    // Entry i holds round(AMPLITUDE * sin(pi/2 * (i + 0.5) / ROM_DEPTH)).
    // The half-step offset makes entry i and entry ~i exact mirrors around
    // the quarter point, so the bitwise-inverted address for odd quadrants
    // reproduces the falling half without any +1 correction.
    // -----------------------------------------------------------------------
    function automatic logic [ROM_DEPTH*MAG_W-1:0] build_rom();
        logic [ROM_DEPTH*MAG_W-1:0] image;
        real                        half_pi;
        real                        level;
        image   = '0;
        half_pi = 3.14159265358979323846 / 2.0;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            level = AMPLITUDE * $sin(half_pi * (i + 0.5) / ROM_DEPTH);
            image[i*MAG_W +: MAG_W] = MAG_W'($rtoi(level + 0.5));
        end
        return image;
    endfunction

    // NOTE: the ROM is a constant, so there is no storage to reset; only the
    // read-data register that follows it is cleared by rst_n_in.
    localparam logic [ROM_DEPTH*MAG_W-1:0] ROM_IMAGE = build_rom();

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    // Audio-rate divider
    logic [DIV_W-1:0]          div_count_q, div_count_d;
    logic                      tick;

    // Phase fields seen at the tick
    logic [1:0]                quadrant;
    logic [LUT_ADDR_WIDTH-1:0] quarter_idx;

    // Whether the sample taken at this tick is audible
    logic                      play_now;

    // S1: captured at the tick
    logic                      s1_valid_q, s1_valid_d;
    logic [LUT_ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
    logic                      s1_neg_q,   s1_neg_d;
    logic                      s1_play_q,  s1_play_d;

    // S2: ROM read data
    logic                      s2_valid_q, s2_valid_d;
    logic                      s2_neg_q,   s2_neg_d;
    logic                      s2_play_q,  s2_play_d;
    logic [MAG_W-1:0]          rom_data_q, rom_data_d;

    // S3: signed value arriving at the output register
    logic signed [SAMPLE_WIDTH-1:0] s3_magnitude;
    logic signed [SAMPLE_WIDTH-1:0] s3_value;

    // Output handshake register
    logic signed [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                           valid_q,  valid_d;
    logic                           overrun_q, overrun_d;

    // Phase bits below the ROM index do not affect the sample.
    logic unused_phase_lsbs;
    assign unused_phase_lsbs = ^phase_value_in[PHASE_WIDTH-LUT_ADDR_WIDTH-3:0];

    // -----------------------------------------------------------------------
    // Phase decode and tick
    // -----------------------------------------------------------------------
    assign tick        = (div_count_q == DIV_LAST);
    assign quadrant    = phase_value_in[PHASE_WIDTH-1 -: 2];
    assign quarter_idx = phase_value_in[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];

`ifdef SINE_ZERO_CROSS_MUTE_EN
    // -----------------------------------------------------------------------
    // Click-free mute FSM. It only moves on ticks. A released note keeps
    // sounding until the quadrant sign bit changes between two consecutive
    // ticks, i.e. the waveform has just crossed zero; that sample and all
    // later ones are silent.
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        MUTED,
        PLAYING,
        RELEASING
    } mute_state_e;

    mute_state_e mute_state_q, mute_state_d;
    logic        prev_half_q,  prev_half_d;

    always_comb begin
        mute_state_d = mute_state_q;
        prev_half_d  = prev_half_q;
        if (tick) begin
            prev_half_d = quadrant[1];
            unique case (mute_state_q)
                MUTED: begin
                    if (gate_in) mute_state_d = PLAYING;
                end
                PLAYING: begin
                    if (!gate_in) mute_state_d = RELEASING;
                end
                RELEASING: begin
                    if (gate_in) begin
                        mute_state_d = PLAYING;
                    end else if (quadrant[1] != prev_half_q) begin
                        mute_state_d = MUTED;
                    end
                end
                default: mute_state_d = MUTED;
            endcase
        end
    end

    // The sample taken at a tick follows the state that tick moves into, so
    // the zero-crossing sample itself is already silent.
    always_comb begin
        play_now = (mute_state_d != MUTED);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mute_state_q <= MUTED;
            prev_half_q  <= 1'b0;
        end else begin
            mute_state_q <= mute_state_d;
            prev_half_q  <= prev_half_d;
        end
    end
`else
    // Immediate mute: a low gate at the tick silences that sample.
    always_comb begin
        play_now = gate_in;
    end
`endif

    // -----------------------------------------------------------------------
    // Divider, pipeline and handshake next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal written in this block is given a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        // Divider wraps at CLK_DIV-1; that terminal count is the tick.
        div_count_d = tick ? '0 : div_count_q + DIV_W'(1);

        // S1: hold the captured fields between ticks.
        s1_valid_d = tick;
        s1_addr_d  = s1_addr_q;
        s1_neg_d   = s1_neg_q;
        s1_play_d  = s1_play_q;
        if (tick) begin
            // Odd quadrants run the quarter wave backwards.
            s1_addr_d = quadrant[0] ? ~quarter_idx : quarter_idx;
            // The second half of the cycle is the negative lobe.
            s1_neg_d  = quadrant[1];
            s1_play_d = play_now;
        end

        // S2: synchronous ROM read and side-band forwarding.
        s2_valid_d = s1_valid_q;
        s2_neg_d   = s1_neg_q;
        s2_play_d  = s1_play_q;
        rom_data_d = ROM_IMAGE[int'(s1_addr_q)*MAG_W +: MAG_W];

        // S3: restore the sign. The magnitude never exceeds 2**(SW-1)-1, so
        // the negation always fits.
        s3_magnitude = signed'({1'b0, rom_data_q});
        if (!s2_play_q) begin
            s3_value = '0;
        end else if (s2_neg_q) begin
            s3_value = -s3_magnitude;
        end else begin
            s3_value = s3_magnitude;
        end

        // Output handshake. A pending sample is never overwritten while the
        // consumer is stalling; the newcomer is dropped and flagged instead.
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (s2_valid_q) begin
            if (!valid_q || sample_ready_in) begin
                sample_d = s3_value;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && sample_ready_in) begin
            valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, regardless of the order
    // the statements are written in.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_count_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_neg_q    <= 1'b0;
            s1_play_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_neg_q    <= 1'b0;
            s2_play_q   <= 1'b0;
            rom_data_q  <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_count_q <= div_count_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_neg_q    <= s1_neg_d;
            s1_play_q   <= s1_play_d;
            s2_valid_q  <= s2_valid_d;
            s2_neg_q    <= s2_neg_d;
            s2_play_q   <= s2_play_d;
            rom_data_q  <= rom_data_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
    assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_sine_sample_stage.sv
// ---------------------------------------------------------------------------
// tb_sine_sample_stage
//
// Self-checking bench for sine_sample_stage with CLK_DIV=4. A behavioural
// reference model predicts every output on every cycle: ticks are derived
// from the cycle count since reset, each tick's sample is computed directly
// from the full-wave sine formula and queued with its arrival time, and the
// output handshake is replayed from the valid/ready rules.
// ---------------------------------------------------------------------------
module tb_sine_sample_stage;

    localparam int  CLK_DIV = 4;
    localparam real PI      = 3.14159265358979323846;
    localparam int  PHASE_STEP = 112404;

    localparam int MODE_MUTED     = 0;
    localparam int MODE_PLAYING   = 1;
    localparam int MODE_RELEASING = 2;

    logic               clk_in;
    logic               rst_n_in;
    logic [31:0]        phase_value_in;
    logic               gate_in;
    logic               sample_ready_in;
    logic signed [15:0] sample_out;
    logic               sample_valid_out;
    logic               overrun_out;

    sine_sample_stage #(
        .PHASE_WIDTH   (32),
        .LUT_ADDR_WIDTH(8),
        .SAMPLE_WIDTH  (16),
        .CLK_DIV       (CLK_DIV)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .phase_value_in  (phase_value_in),
        .gate_in         (gate_in),
        .sample_ready_in (sample_ready_in),
        .sample_out      (sample_out),
        .sample_valid_out(sample_valid_out),
        .overrun_out     (overrun_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // -----------------------------------------------------------------------
    // Reference model state
    // -----------------------------------------------------------------------
    typedef struct {
        int                 due;
        logic signed [15:0] value;
    } pending_t;

    typedef struct {
        logic [31:0]        phase;
        logic               gate;
        logic signed [15:0] expected;
    } vec_t;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 edge_n   = 0;
    pending_t           pend_q[$];
    logic signed [15:0] m_sample;
    logic               m_valid;
    logic               m_overrun;
    int                 m_mode;
    logic               m_prev_half;
    vec_t               vecs[$];

    // Full-wave sine sampled at the centre of the 1024-step phase bin.
    function automatic logic signed [15:0] ref_sine(input logic [31:0] ph);
        real v;
        int  p;
        p = int'(ph[31:22]);
        v = 32767.0 * $sin(2.0 * PI * (p + 0.5) / 1024.0);
        return 16'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
    endfunction

    task automatic model_reset();
        edge_n      = 0;
        pend_q.delete();
        m_sample    = '0;
        m_valid     = 1'b0;
        m_overrun   = 1'b0;
        m_mode      = MODE_MUTED;
        m_prev_half = 1'b0;
    endtask

    // Called once per rising edge with the inputs the DUT saw at that edge.
    task automatic model_edge();
        logic     play;
        pending_t p;
        edge_n++;
        if (edge_n % CLK_DIV == 0) begin
`ifdef SINE_ZERO_CROSS_MUTE_EN
            if (m_mode == MODE_MUTED && gate_in) begin
                m_mode = MODE_PLAYING;
            end else if (m_mode == MODE_PLAYING && !gate_in) begin
                m_mode = MODE_RELEASING;
            end else if (m_mode == MODE_RELEASING) begin
                if (gate_in) m_mode = MODE_PLAYING;
                else if (phase_value_in[31] != m_prev_half) m_mode = MODE_MUTED;
            end
            m_prev_half = phase_value_in[31];
            play = (m_mode != MODE_MUTED);
`else
            play = gate_in;
`endif
            p.due   = edge_n + 2;
            p.value = play ? ref_sine(phase_value_in) : 16'sd0;
            pend_q.push_back(p);
        end
        if (pend_q.size() != 0 && pend_q[0].due == edge_n) begin
            p = pend_q.pop_front();
            if (!m_valid || sample_ready_in) begin
                m_sample = p.value;
                m_valid  = 1'b1;
            end else begin
                m_overrun = 1'b1;
            end
        end else if (m_valid && sample_ready_in) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, exp);
        end
    endtask

    // One clock: update the model at the rising edge, compare at the falling.
    task automatic step();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        check("sample_out", 32'(sample_out), 32'(m_sample));
        check("sample_valid_out", 32'(sample_valid_out), 32'(m_valid));
        check("overrun_out", 32'(overrun_out), 32'(m_overrun));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        int first_valid;
        int nonzero_after_drop;

        rst_n_in        = 1'b0;
        phase_value_in  = '0;
        gate_in         = 1'b1;
        sample_ready_in = 1'b1;
        model_reset();

        vecs.push_back('{32'h0000_0000, 1'b1, 16'sd101});
        vecs.push_back('{32'h4000_0000, 1'b1, 16'sd32767});
        vecs.push_back('{32'h8000_0000, 1'b1, -16'sd101});
        vecs.push_back('{32'hC000_0000, 1'b1, -16'sd32767});
        vecs.push_back('{32'h3FFF_FFFF, 1'b1, 16'sd32767});
        vecs.push_back('{32'h7FFF_FFFF, 1'b1, 16'sd101});
        vecs.push_back('{32'hBFFF_FFFF, 1'b1, -16'sd32767});
        vecs.push_back('{32'hFFFF_FFFF, 1'b1, -16'sd101});
`ifndef SINE_ZERO_CROSS_MUTE_EN
        vecs.push_back('{32'h4000_0000, 1'b0, 16'sd0});
        vecs.push_back('{32'hC000_0000, 1'b0, 16'sd0});
`endif
        vecs.push_back('{32'h0040_0000, 1'b1, ref_sine(32'h0040_0000)});

        // Reset state
        repeat (3) @(negedge clk_in);
        check("reset_sample", 32'(sample_out), 32'd0);
        check("reset_valid", 32'(sample_valid_out), 32'd0);
        check("reset_overrun", 32'(overrun_out), 32'd0);
        rst_n_in = 1'b1;
        model_reset();

        // Table-driven phase/gate vectors, consumer always ready
        foreach (vecs[k]) begin
            phase_value_in  = vecs[k].phase;
            gate_in         = vecs[k].gate;
            sample_ready_in = 1'b1;
            repeat (8) step();
            check($sformatf("vec%0d_sample", k), 32'(sample_out), 32'(vecs[k].expected));
        end
        check("no_overrun_when_ready", 32'(overrun_out), 32'd0);

        // Backpressure: first sample held, later ones dropped, overrun sticks
        phase_value_in  = 32'h4000_0000;
        gate_in         = 1'b1;
        sample_ready_in = 1'b1;
        repeat (8) step();
        sample_ready_in = 1'b0;
        repeat (10) step();
        check("stall_held_sample", 32'(sample_out), 32'(16'sd32767));
        check("stall_valid_held", 32'(sample_valid_out), 32'd1);
        check("stall_overrun", 32'(overrun_out), 32'd1);
        if ((edge_n + 1) % CLK_DIV == 2) step();
        sample_ready_in = 1'b1;
        step();
        check("release_valid_falls", 32'(sample_valid_out), 32'd0);
        check("release_overrun_sticky", 32'(overrun_out), 32'd1);
        check("release_sample_kept", 32'(sample_out), 32'(16'sd32767));

        // Reset mid-pipeline, just after a tick has been captured
        phase_value_in = 32'h8000_0000;
        for (int i = 0; i < CLK_DIV && (edge_n % CLK_DIV) != 1; i++) step();
        rst_n_in = 1'b0;
        #1;
        check("midreset_sample", 32'(sample_out), 32'd0);
        check("midreset_valid", 32'(sample_valid_out), 32'd0);
        check("midreset_overrun", 32'(overrun_out), 32'd0);
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        first_valid = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (first_valid < 0 && sample_valid_out) first_valid = i;
        end
        check("first_valid_edge_after_reset", 32'(first_valid), 32'd6);
        check("first_sample_after_reset", 32'(sample_out), 32'(-16'sd101));

        // Randomized phase, gate and backpressure
        for (int i = 0; i < 400; i++) begin
            phase_value_in  = $urandom();
            gate_in         = ($urandom_range(0, 4) != 0);
            sample_ready_in = ($urandom_range(0, 3) != 0);
            step();
        end

`ifdef SINE_ZERO_CROSS_MUTE_EN
        // Running accumulator; gate dropped in the positive half cycle
        rst_n_in = 1'b0;
        @(negedge clk_in);
        model_reset();
        rst_n_in        = 1'b1;
        phase_value_in  = '0;
        gate_in         = 1'b1;
        sample_ready_in = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            step();
            phase_value_in = phase_value_in + 32'(PHASE_STEP);
        end
        gate_in = 1'b0;
        nonzero_after_drop = 0;
        for (int i = 0; i < 20000 && !phase_value_in[31]; i++) begin
            step();
            if (sample_valid_out && sample_out != 16'sd0) nonzero_after_drop++;
            phase_value_in = phase_value_in + 32'(PHASE_STEP);
        end
        repeat (12) begin
            step();
            phase_value_in = phase_value_in + 32'(PHASE_STEP);
        end
        check("release_keeps_sounding", 32'(nonzero_after_drop != 0), 32'd1);
        check("muted_after_zero_cross", 32'(sample_out), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
